mpadd_seq: RTL
==============

Name: mpadd_seq

Overview:
Multi-precision add/subtract sequencer. It performs one WORDS×32-bit addition or subtraction by driving a single shared 32-bit ripple-carry adder (rcadd32) one word per cycle, least-significant word first. Between words it holds the carry in a register. It sits between a requester, on a valid/ready operand interface, and a consumer, on a valid/ready result interface. Its purpose is to let wide arithmetic reuse the existing 32-bit adder instead of instantiating a wide one.

Parameters:
WORDS, 4, number of 32-bit words per operand; legal range 2..16. Total operand width is N = 32*WORDS.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
start_valid  input  1  requester presents an operation
start_ready  output  1  block can accept an operation
op_sub  input  1  0 = a+b, 1 = a-b; sampled on accept
a  input  N  operand A; sampled on accept
b  input  N  operand B; sampled on accept
res_valid  output  1  result available
res_ready  input  1  consumer takes the result
sum  output  N  result
cout  output  1  final carry out; for subtract, 1 = no borrow (a >= b unsigned)
ovf  output  1  two's-complement signed overflow of the N-bit operation

Behaviour:
- One clock domain: clk. Reset is rst_n, asynchronous assert, active-low.
- Reset state:
  - FSM = IDLE; word counter = 0; carry register = 0.
  - sum = 0, cout = 0, ovf = 0, res_valid = 0.
  - start_ready = 0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready:
    - latch a, b and op_sub into the operand registers;
    - set carry register = op_sub;
    - set counter = 0;
    - go to RUN.
  - a and b are not sampled in any other state.
- RUN:
  - start_ready = 0.
  - Each cycle, drive the adder with:
    - adder a = A word [counter];
    - adder b = B word [counter], bit-inverted when op_sub = 1;
    - adder cin = carry register.
  - On the clock edge:
    - write the adder sum into sum word [counter];
    - carry register <= adder cout;
    - counter <= counter + 1.
  - On the last word (counter == WORDS-1):
    - cout <= adder cout;
    - ovf <= (a_msb == b_eff_msb) & (sum_msb != a_msb), where b_eff is B after optional inversion;
    - go to DONE.
- DONE:
  - res_valid = 1.
  - sum, cout and ovf are held stable while res_valid is high and res_ready is low.
  - On res_ready = 1: clear res_valid and go to IDLE.
- Latency: res_valid is high in the cycle that begins exactly WORDS rising edges after the accepting edge.
- Throughput: one operation per WORDS+2 cycles. No new operation is accepted in the same cycle as a result handshake.
- start_valid is ignored in RUN and DONE. The requester may hold it high, and no operand is captured until IDLE.
- res_ready is ignored unless res_valid = 1.
- sum word registers are updated only in RUN. The previous result remains visible in IDLE until overwritten; consumers must qualify it with res_valid.
- Counter: $clog2(WORDS) bits wide; it never wraps past WORDS-1 while in RUN.
- Reset mid-operation (RUN or DONE): all state returns to the reset values and the partial result is discarded. The next accepted operation starts with a clean carry.
- The adder is purely combinational; the block adds no extra pipeline stages around it.

Decomposition:
- Package mpadd_pkg holds:
  - state enum: IDLE, RUN, DONE;
  - constant WORD_W = 32;
  - helper function for the counter width.
- Sub-module: one instance of the existing rcadd32 is the datapath. Operand word select, B inversion, carry register and FSM stay inline.

Test Plan:
1. WORDS=4, add a = 2^128-1, b = 1 -> sum = 0, cout = 1, ovf = 0. res_valid rises exactly 4 edges after the accept edge.
2. Subtract a = 0, b = 1 -> sum = 0xFFFF…FFFF (128 bits), cout = 0 (borrow), ovf = 0.
3. Add a = 0x7FFF…FFFF, b = 1 -> sum = 0x8000…0000, ovf = 1, cout = 0. Subtract a = 0x8000…0000, b = 1 -> sum = 0x7FFF…FFFF, ovf = 1, cout = 1.
4. Carry across word boundaries: add a = 0x00000000_FFFFFFFF_00000000_FFFFFFFF, b = 0x00000000_00000001_00000000_00000001 -> sum = 0x00000001_00000000_00000001_00000000, cout = 0.
5. Backpressure: hold res_ready = 0 for 10 cycles with start_valid = 1 and new operands -> res_valid, sum, cout and ovf stay constant and start_ready stays 0. On res_ready = 1: one handshake, start_ready = 1 the next cycle, and the new operation completes correctly.
6. Reset mid-RUN: assert rst_n low after word 2 of an add with cout = 1 pending -> res_valid = 0 and sum = 0 immediately. After release, 5 + 3 gives sum = 8, cout = 0, with no stale carry.

Source files
------------

// File: rtl/mpadd_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mpadd_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Word counter width; at least one bit so a 1-word build still elaborates.
   function automatic int cnt_w(input int words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/rcadd32.sv
// 32-bit ripple-carry adder, purely combinational.
module rcadd32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [32:0] cy;

   assign cy[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b[i] ^ cy[i];
      assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
   end

   assign cout = cy[32];

endmodule

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract: walks WORDS 32-bit words through one shared
// rcadd32, LSW first, holding the inter-word carry in a register.
module mpadd_seq
   import mpadd_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic                      op_sub,
   input  logic [WORD_W*WORDS-1:0]   a,
   input  logic [WORD_W*WORDS-1:0]   b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [WORD_W*WORDS-1:0]   sum,
   output logic                      cout,
   output logic                      ovf
);

   localparam int CW = cnt_w(WORDS);
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   typedef logic [WORDS-1:0][WORD_W-1:0] vec_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            sub_q, sub_d;
   vec_t            a_q, a_d;
   vec_t            b_q, b_d;
   vec_t            sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [WORD_W-1:0] add_a, add_b, add_s;
   logic              add_co;

   // Subtract is a + ~b + 1; the +1 enters through the preset carry.
   assign add_a = a_q[cnt_q];
   assign add_b = b_q[cnt_q] ^ {WORD_W{sub_q}};

   rcadd32 u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_s),
      .cout (add_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start_valid) begin
               a_d     = vec_t'(a);
               b_d     = vec_t'(b);
               sub_d   = op_sub;
               carry_d = op_sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[cnt_q] = add_s;
            carry_d      = add_co;
            if (cnt_q == LAST) begin
               cout_d  = add_co;
               ovf_d   = (add_a[WORD_W-1] == add_b[WORD_W-1]) &
                         (add_s[WORD_W-1] != add_a[WORD_W-1]);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Gated by rst_n so nothing is offered while reset is held.
   assign start_ready = rst_n & (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign ovf         = ovf_q;

endmodule
